serial_adder: RTL
=================

// Module: serial_adder
// PURPOSE
//   Bit-serial WIDTH-bit adder built around one full_adder instance.
//   - Operands are latched on START and shifted through the full_adder LSB-first, one bit per clock.
//   - Carry is held in a flip-flop between bits.
//   - Sum bits are collected into a result register; SUM/COUT are presented with a one-cycle DONE pulse.
//   - Trades WIDTH cycles of latency for single-cell area; a drop-in alternative to the ripple adder.
// PARAMETERS
//   WIDTH  8  operand/sum width in bits; legal range 1..32
// PORTS
//   CLK    input   1      rising-edge clock, single clock domain
//   RST_N  input   1      reset, asynchronous assert, active-low
//   START  input   1      request: latch A, B, CIN and begin an addition
//   A      input   WIDTH  operand A, sampled only when START is accepted
//   B      input   WIDTH  operand B, sampled only when START is accepted
//   CIN    input   1      carry-in, sampled only when START is accepted
//   BUSY   output  1      high while an addition is in progress
//   DONE   output  1      one-cycle pulse: SUM/COUT just updated
//   SUM    output  WIDTH  result register; holds the last completed sum
//   COUT   output  1      carry-out of the last completed sum
// BEHAVIOUR
//   Clock/reset: one clock CLK; RST_N is asynchronous and active-low.
//   Reset (RST_N=0, async): state=IDLE; BUSY=0, DONE=0, SUM=0, COUT=0.
//     Shift registers, carry flop and bit counter are cleared.
//     Mid-operation reset aborts the addition; no DONE follows.
//   States:
//     IDLE  BUSY=0, DONE=0.
//     RUN   BUSY=1, DONE=0.
//     FIN   BUSY=0, DONE=1, one cycle only.
//   Transitions:
//     IDLE -> RUN   on START=1. Load opA<=A, opB<=B, carry<=CIN, cnt<=0.
//     RUN  -> RUN   while cnt < WIDTH-1. Per edge:
//                     full_adder X=opA[0], Y=opB[0], Z=carry.
//                     res <= {S, res[WIDTH-1:1]}; carry <= C.
//                     opA, opB shift right by 1; cnt++.
//     RUN  -> FIN   on the edge processing bit cnt=WIDTH-1.
//                     SUM <= final res (including that S); COUT <= C.
//     FIN  -> RUN   if START=1 (back-to-back; reload as from IDLE).
//     FIN  -> IDLE  otherwise.
//   Handshake and latency:
//     - START is ignored while in RUN (no queueing, operands not resampled).
//     - START sampled at edge e0 => DONE=1 in the cycle after edge e0+WIDTH.
//     - Throughput: one result per WIDTH+1 cycles.
//   Output stability:
//     - SUM/COUT change only on the RUN->FIN edge.
//     - During RUN they hold the previous result, or 0 after reset.
//   Arithmetic: {COUT,SUM} == A + B + CIN, modulo 2^(WIDTH+1), unsigned. No overflow flag.
//   WIDTH=1: RUN lasts one cycle; DONE is high in the cycle after the edge following START.
//   Counter width: $clog2(WIDTH+1) bits; counter never wraps within a run.
// TESTING
//   1. WIDTH=8: A=8'hFF, B=8'h01, CIN=0, START pulsed at edge e0.
//      -> BUSY=1 from e0 for 8 cycles; DONE pulses once after e8; SUM=8'h00, COUT=1.
//   2. A=8'h3C, B=8'h42, CIN=0 -> SUM=8'h7E, COUT=0.
//      A=8'h5A, B=8'hA5, CIN=1 -> SUM=8'h00, COUT=1.
//   3. START=1 again at cycle 3 of RUN with A=8'h11, B=8'h22.
//      -> ignored; result is still from the original operands; exactly one DONE.
//   4. RST_N low mid-RUN (after 4 bits).
//      -> BUSY, DONE, SUM, COUT = 0 immediately, no DONE afterwards.
//      -> A following START computes correctly.
//   5. START held high through FIN (back-to-back, new operands).
//      -> second DONE exactly 9 cycles after the first; both sums correct.
//   6. 1000 random {A,B,CIN} with random START gaps, for WIDTH=8 and WIDTH=1.
//      -> every DONE has {COUT,SUM} equal to the reference model A+B+CIN.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder cell, operands shifted LSB-first, carry held in a flop.
// START at edge e0 gives a one-cycle DONE after edge e0+WIDTH; START is ignored while BUSY.

module full_adder (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic s,
  output logic c
);
  assign s = x ^ y ^ z;
  assign c = (x & y) | (z & (x ^ y));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_next;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s;
  logic             fa_c;

  full_adder u_fa (
    .x(op_a[0]),
    .y(op_b[0]),
    .z(carry),
    .s(fa_s),
    .c(fa_c)
  );

  // New sum bit enters at the MSB; written this way so WIDTH=1 needs no empty slice.
  always_comb begin
    res_next            = res >> 1;
    res_next[WIDTH-1]   = fa_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      op_a  <= '0;
      op_b  <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == RUN) begin
        res   <= res_next;
        carry <= fa_c;
        op_a  <= op_a >> 1;
        op_b  <= op_b >> 1;
        cnt   <= cnt + CW'(1);
        if (cnt == LAST) begin
          state <= FIN;
          busy  <= 1'b0;
          done  <= 1'b1;
          sum   <= res_next;
          cout  <= fa_c;
        end
      end else if (start) begin
        // IDLE and FIN both accept a new request, giving back-to-back operation.
        state <= RUN;
        op_a  <= a;
        op_b  <= b;
        carry <= cin;
        cnt   <= '0;
        busy  <= 1'b1;
      end else begin
        state <= IDLE;
        busy  <= 1'b0;
      end
    end
  end
endmodule
